// File: rtl/riscv_mc_control.sv
// riscv_mc_control: multi-cycle control sequencer for an RV32I core.
// The FSM walks IDLE -> FETCH -> DECODE -> EXEC -> (MEM) -> (WB) -> FETCH. It
// traps on an illegal opcode or on a data-memory timeout. It also counts
// retired instructions, which are the cycles that update the PC.
// Ports:
//   clk, resetn         clock, asynchronous active-low reset
//   instr_i             latched instruction (valid from DECODE onward)
//   imem_rvalid_i       instruction-memory response valid (sampled in FETCH)
//   dmem_rvalid_i       data-memory response/ack valid (sampled in MEM)
//   br_taken_i          branch comparator result (sampled in EXEC)
//   imem_req_o, ir_we_o fetch request / instruction-register load
//   dmem_req_o, dmem_we_o data request / write enable
//   pc_we_o, pc_sel_o   PC update and source (00 +4, 01 +imm, 10 ALU&~1)
//   op1_sel_o, op2_sel_o ALU operand selects (rs1/PC, rs2/imm)
//   wb_sel_o, rf_en_o   writeback source (ALU/mem/PC+4/imm) and RF write
//   alu_op_o            ALU function code
//   trap_o              sticky fault flag
//   retired_o           retired-instruction count (wraps)
module riscv_mc_control #(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [31:0]      instr_i,
  input  logic             imem_rvalid_i,
  input  logic             dmem_rvalid_i,
  input  logic             br_taken_i,
  output logic             imem_req_o,
  output logic             ir_we_o,
  output logic             dmem_req_o,
  output logic             dmem_we_o,
  output logic             pc_we_o,
  output logic [1:0]       pc_sel_o,
  output logic             op1_sel_o,
  output logic             op2_sel_o,
  output logic [1:0]       wb_sel_o,
  output logic             rf_en_o,
  output logic [3:0]       alu_op_o,
  output logic             trap_o,
  output logic [CNT_W-1:0] retired_o
);

  localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLL  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_SLT  = 4'd8;
  localparam logic [3:0] ALU_SLTU = 4'd9;

  typedef enum logic [2:0] {
    ST_IDLE, ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM, ST_WB, ST_TRAP
  } state_e;

  state_e             state_q, state_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic [CNT_W-1:0]   retired_q, retired_d;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       f7b5;
  logic is_r, is_i, is_ld, is_st, is_br, is_jal, is_jalr, is_lui, is_auipc;
  logic legal;
  logic unused_instr_bits;

  assign opcode = instr_i[6:0];
  assign funct3 = instr_i[14:12];
  assign f7b5   = instr_i[30];
  assign unused_instr_bits = ^{instr_i[31], instr_i[29:15], instr_i[11:7]};

  assign is_r     = (opcode == 7'h33);
  assign is_i     = (opcode == 7'h13);
  assign is_ld    = (opcode == 7'h03);
  assign is_st    = (opcode == 7'h23);
  assign is_br    = (opcode == 7'h63);
  assign is_jal   = (opcode == 7'h6F);
  assign is_jalr  = (opcode == 7'h67);
  assign is_lui   = (opcode == 7'h37);
  assign is_auipc = (opcode == 7'h17);
  assign legal    = is_r | is_i | is_ld | is_st | is_br | is_jal | is_jalr |
                    is_lui | is_auipc;

  function automatic logic [3:0] alu_fn(input logic [2:0] f3, input logic alt);
    logic [3:0] op;
    case (f3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  // State register and sequencing counters
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= ST_IDLE;
      wait_q    <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      retired_q <= retired_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    wait_d  = '0;
    case (state_q)
      ST_IDLE:   state_d = ST_FETCH;
      ST_FETCH:  if (imem_rvalid_i) state_d = ST_DECODE;
      ST_DECODE: state_d = legal ? ST_EXEC : ST_TRAP;
      ST_EXEC: begin
        if (is_br)              state_d = ST_FETCH;
        else if (is_ld | is_st) state_d = ST_MEM;
        else                    state_d = ST_WB;
      end
      ST_MEM: begin
        // A response on the final allowed cycle still wins over the timeout
        if (dmem_rvalid_i)
          state_d = is_ld ? ST_WB : ST_FETCH;
        else if (wait_q == WAIT_W'(TIMEOUT - 1))
          state_d = ST_TRAP;
        else
          wait_d = wait_q + 1'b1;
      end
      ST_WB:   state_d = ST_FETCH;
      ST_TRAP: state_d = ST_TRAP;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    imem_req_o = 1'b0;
    ir_we_o    = 1'b0;
    dmem_req_o = 1'b0;
    dmem_we_o  = 1'b0;
    pc_we_o    = 1'b0;
    pc_sel_o   = 2'b00;
    op1_sel_o  = 1'b0;
    op2_sel_o  = 1'b0;
    wb_sel_o   = 2'b00;
    rf_en_o    = 1'b0;
    alu_op_o   = ALU_ADD;
    trap_o     = 1'b0;

    // ALU controls are held through MEM and WB so the address / result
    // stays stable without a separate ALU output register.
    if (state_q == ST_EXEC || state_q == ST_MEM || state_q == ST_WB) begin
      if (is_r) begin
        alu_op_o = alu_fn(funct3, f7b5);
      end else if (is_i) begin
        op2_sel_o = 1'b1;
        alu_op_o  = alu_fn(funct3, (funct3 == 3'b101) & f7b5);
      end else if (is_ld | is_st | is_jalr) begin
        op2_sel_o = 1'b1;
      end else if (is_auipc) begin
        op1_sel_o = 1'b1;
        op2_sel_o = 1'b1;
      end
    end

    case (state_q)
      ST_FETCH: begin
        imem_req_o = 1'b1;
        ir_we_o    = imem_rvalid_i;
      end
      ST_EXEC: begin
        if (is_br) begin
          pc_we_o  = 1'b1;
          pc_sel_o = br_taken_i ? 2'b01 : 2'b00;
        end
      end
      ST_MEM: begin
        dmem_req_o = 1'b1;
        dmem_we_o  = is_st;
        pc_we_o    = is_st & dmem_rvalid_i;
      end
      ST_WB: begin
        rf_en_o = 1'b1;
        pc_we_o = 1'b1;
        if (is_ld)                 wb_sel_o = 2'b01;
        else if (is_jal | is_jalr) wb_sel_o = 2'b10;
        else if (is_lui)           wb_sel_o = 2'b11;
        if (is_jal)       pc_sel_o = 2'b01;
        else if (is_jalr) pc_sel_o = 2'b10;
      end
      ST_TRAP: trap_o = 1'b1;
      default: ;
    endcase
  end

  assign retired_d = pc_we_o ? retired_q + CNT_W'(1) : retired_q;
  assign retired_o = retired_q;

endmodule

// File: tb/tb_riscv_mc_control.sv
module tb_riscv_mc_control;

  logic        clk;
  logic        resetn;
  logic [31:0] instr;
  logic        imem_rvalid, dmem_rvalid, br_taken;

  logic        imem_req, ir_we, dmem_req, dmem_we, pc_we, op1_sel, op2_sel, rf_en, trap;
  logic [1:0]  pc_sel, wb_sel;
  logic [3:0]  alu_op;
  logic [31:0] retired;

  logic        imem_req4, ir_we4, dmem_req4, dmem_we4, pc_we4, op1_sel4, op2_sel4, rf_en4, trap4;
  logic [1:0]  pc_sel4, wb_sel4;
  logic [3:0]  alu_op4;
  logic [3:0]  retired4;

  logic [16:0] ctl;
  assign ctl = {imem_req, ir_we, dmem_req, dmem_we, pc_we, pc_sel, op1_sel, op2_sel,
                wb_sel, rf_en, alu_op, trap};

  int n_checks = 0;
  int n_fail   = 0;

  riscv_mc_control #(.CNT_W(32), .TIMEOUT(16)) dut (
    .clk(clk), .resetn(resetn), .instr_i(instr),
    .imem_rvalid_i(imem_rvalid), .dmem_rvalid_i(dmem_rvalid), .br_taken_i(br_taken),
    .imem_req_o(imem_req), .ir_we_o(ir_we), .dmem_req_o(dmem_req), .dmem_we_o(dmem_we),
    .pc_we_o(pc_we), .pc_sel_o(pc_sel), .op1_sel_o(op1_sel), .op2_sel_o(op2_sel),
    .wb_sel_o(wb_sel), .rf_en_o(rf_en), .alu_op_o(alu_op), .trap_o(trap),
    .retired_o(retired)
  );

  riscv_mc_control #(.CNT_W(4), .TIMEOUT(16)) dut4 (
    .clk(clk), .resetn(resetn), .instr_i(instr),
    .imem_rvalid_i(imem_rvalid), .dmem_rvalid_i(dmem_rvalid), .br_taken_i(br_taken),
    .imem_req_o(imem_req4), .ir_we_o(ir_we4), .dmem_req_o(dmem_req4), .dmem_we_o(dmem_we4),
    .pc_we_o(pc_we4), .pc_sel_o(pc_sel4), .op1_sel_o(op1_sel4), .op2_sel_o(op2_sel4),
    .wb_sel_o(wb_sel4), .rf_en_o(rf_en4), .alu_op_o(alu_op4), .trap_o(trap4),
    .retired_o(retired4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stimulus: inputs change on the falling edge, outputs sampled 1 later.
  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0; imem_rvalid = 1'b0; dmem_rvalid = 1'b0; br_taken = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
  endtask

  // Fetch (zero-wait) and decode an instruction; returns sampled in EXEC.
  task automatic to_exec(input logic [31:0] ins);
    instr = ins;
    @(negedge clk); imem_rvalid = 1'b1;
    @(negedge clk); imem_rvalid = 1'b0;
    @(negedge clk); #1;
  endtask

  task automatic run_alu();
    to_exec(32'h002081B3);
    @(negedge clk); #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0; instr = '0; imem_rvalid = 1'b0; dmem_rvalid = 1'b0; br_taken = 1'b0;
    #1;
    n_checks++; if (ctl !== 17'h0) begin n_fail++; $display("FAIL reset_ctl got=%h exp=0", ctl); end
    n_checks++; if (retired !== 32'd0) begin n_fail++; $display("FAIL reset_retired got=%0d exp=0", retired); end
    @(negedge clk); resetn = 1'b1; #1;
    n_checks++; if (ctl !== 17'h0) begin n_fail++; $display("FAIL idle_ctl got=%h exp=0", ctl); end
  endtask

  task automatic test_add();
    do_reset();
    instr = 32'h002081B3;
    @(negedge clk); imem_rvalid = 1'b1; #1;
    n_checks++; if ({imem_req, ir_we, pc_we} !== 3'b110) begin n_fail++; $display("FAIL add_fetch got=%b exp=110", {imem_req, ir_we, pc_we}); end
    @(negedge clk); imem_rvalid = 1'b0; #1;
    n_checks++; if ({imem_req, ir_we, pc_we, rf_en, trap} !== 5'b0) begin n_fail++; $display("FAIL add_decode got=%b exp=00000", {imem_req, ir_we, pc_we, rf_en, trap}); end
    @(negedge clk); #1;
    n_checks++; if ({op1_sel, op2_sel, alu_op, pc_we, rf_en} !== 8'b0) begin n_fail++; $display("FAIL add_exec got=%b exp=0", {op1_sel, op2_sel, alu_op, pc_we, rf_en}); end
    @(negedge clk); #1;
    n_checks++; if ({rf_en, pc_we, wb_sel, pc_sel, op2_sel, alu_op} !== 11'b110_0000_0000) begin n_fail++; $display("FAIL add_wb got=%b exp=11000000000", {rf_en, pc_we, wb_sel, pc_sel, op2_sel, alu_op}); end
    n_checks++; if (retired !== 32'd0) begin n_fail++; $display("FAIL add_retired_wb got=%0d exp=0", retired); end
    @(negedge clk); #1;
    n_checks++; if ({imem_req, retired} !== {1'b1, 32'd1}) begin n_fail++; $display("FAIL add_next got=%b/%0d exp=1/1", imem_req, retired); end
  endtask

  task automatic test_classes();
    logic [31:0] ins [8]  = '{32'h402081B3, 32'h4030D093, 32'hC0000093, 32'h000010B7,
                              32'h0000006F, 32'h00008067, 32'h00000097, 32'h0020F1B3};
    logic [5:0]  ex  [8]  = '{6'b00_0001, 6'b01_0111, 6'b01_0000, 6'b00_0000,
                              6'b00_0000, 6'b01_0000, 6'b11_0000, 6'b00_0010};
    logic [3:0]  wb  [8]  = '{4'b0000, 4'b0000, 4'b0000, 4'b1100,
                              4'b1001, 4'b1010, 4'b0000, 4'b0000};
    do_reset();
    for (int i = 0; i < 8; i++) begin
      to_exec(ins[i]);
      n_checks++; if ({op1_sel, op2_sel, alu_op} !== ex[i]) begin n_fail++; $display("FAIL class_exec[%0d] got=%b exp=%b", i, {op1_sel, op2_sel, alu_op}, ex[i]); end
      @(negedge clk); #1;
      n_checks++; if ({wb_sel, pc_sel, rf_en, pc_we} !== {wb[i], 2'b11}) begin n_fail++; $display("FAIL class_wb[%0d] got=%b exp=%b", i, {wb_sel, pc_sel, rf_en, pc_we}, {wb[i], 2'b11}); end
    end
    @(negedge clk); #1;
    n_checks++; if (retired !== 32'd8) begin n_fail++; $display("FAIL class_retired got=%0d exp=8", retired); end
  endtask

  task automatic test_load();
    do_reset();
    to_exec(32'h0000A283);
    n_checks++; if ({op2_sel, alu_op, dmem_req} !== 6'b1_0000_0) begin n_fail++; $display("FAIL load_exec got=%b exp=100000", {op2_sel, alu_op, dmem_req}); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); dmem_rvalid = (i == 3); #1;
      n_checks++; if ({dmem_req, dmem_we, rf_en, pc_we} !== 4'b1000) begin n_fail++; $display("FAIL load_mem[%0d] got=%b exp=1000", i, {dmem_req, dmem_we, rf_en, pc_we}); end
    end
    @(negedge clk); dmem_rvalid = 1'b0; #1;
    n_checks++; if ({rf_en, pc_we, wb_sel, dmem_req} !== 5'b11010) begin n_fail++; $display("FAIL load_wb got=%b exp=11010", {rf_en, pc_we, wb_sel, dmem_req}); end
    @(negedge clk); #1;
    n_checks++; if ({imem_req, retired} !== {1'b1, 32'd1}) begin n_fail++; $display("FAIL load_next got=%b/%0d exp=1/1", imem_req, retired); end
  endtask

  task automatic test_branch();
    do_reset();
    br_taken = 1'b1;
    to_exec(32'h00000063);
    n_checks++; if ({pc_we, pc_sel, rf_en} !== 4'b1010) begin n_fail++; $display("FAIL br_taken got=%b exp=1010", {pc_we, pc_sel, rf_en}); end
    br_taken = 1'b0;
    to_exec(32'h00000063);
    n_checks++; if ({pc_we, pc_sel, rf_en} !== 4'b1000) begin n_fail++; $display("FAIL br_not_taken got=%b exp=1000", {pc_we, pc_sel, rf_en}); end
    n_checks++; if (retired !== 32'd1) begin n_fail++; $display("FAIL br_retired_mid got=%0d exp=1", retired); end
    @(negedge clk); #1;
    n_checks++; if ({imem_req, retired} !== {1'b1, 32'd2}) begin n_fail++; $display("FAIL br_next got=%b/%0d exp=1/2", imem_req, retired); end
  endtask

  task automatic test_illegal();
    do_reset();
    instr = 32'h00000000;
    @(negedge clk); imem_rvalid = 1'b1;
    @(negedge clk); imem_rvalid = 1'b0; #1;
    n_checks++; if (trap !== 1'b0) begin n_fail++; $display("FAIL illegal_decode got=%b exp=0", trap); end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); imem_rvalid = 1'b1; dmem_rvalid = 1'b1; #1;
      n_checks++; if ({trap, imem_req, ir_we, pc_we, rf_en, dmem_req, retired} !== {6'b100000, 32'd0}) begin n_fail++; $display("FAIL illegal_trap[%0d] got=%b/%0d exp=100000/0", i, {trap, imem_req, ir_we, pc_we, rf_en, dmem_req}, retired); end
    end
    imem_rvalid = 1'b0; dmem_rvalid = 1'b0;
  endtask

  task automatic test_store_timeout();
    do_reset();
    to_exec(32'h0020A023);
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk); #1;
      n_checks++; if ({dmem_req, dmem_we, trap, pc_we} !== 4'b1100) begin n_fail++; $display("FAIL st_to_mem[%0d] got=%b exp=1100", i, {dmem_req, dmem_we, trap, pc_we}); end
    end
    @(negedge clk); #1;
    n_checks++; if ({trap, dmem_req, dmem_we, retired} !== {3'b100, 32'd0}) begin n_fail++; $display("FAIL st_to_trap got=%b/%0d exp=100/0", {trap, dmem_req, dmem_we}, retired); end

    do_reset();
    to_exec(32'h0020A023);
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk); dmem_rvalid = (i == 16); #1;
      n_checks++; if ({dmem_req, dmem_we, trap, pc_we, pc_sel} !== {3'b110, (i == 16), 2'b00}) begin n_fail++; $display("FAIL st_late[%0d] got=%b exp=%b", i, {dmem_req, dmem_we, trap, pc_we, pc_sel}, {3'b110, (i == 16), 2'b00}); end
    end
    @(negedge clk); dmem_rvalid = 1'b0; #1;
    n_checks++; if ({imem_req, trap, retired} !== {2'b10, 32'd1}) begin n_fail++; $display("FAIL st_late_next got=%b/%0d exp=10/1", {imem_req, trap}, retired); end
  endtask

  task automatic test_wrap();
    do_reset();
    repeat (16) run_alu();
    n_checks++; if (retired4 !== 4'hF) begin n_fail++; $display("FAIL wrap_pre got=%0d exp=15", retired4); end
    @(negedge clk); #1;
    n_checks++; if (retired4 !== 4'h0) begin n_fail++; $display("FAIL wrap_cnt4 got=%0d exp=0", retired4); end
    n_checks++; if (retired !== 32'd16) begin n_fail++; $display("FAIL wrap_cnt32 got=%0d exp=16", retired); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    to_exec(32'h0000A283);
    @(negedge clk); #1;
    n_checks++; if (dmem_req !== 1'b1) begin n_fail++; $display("FAIL rst_mid_mem got=%b exp=1", dmem_req); end
    #2 resetn = 1'b0;
    #1;
    n_checks++; if ({ctl, retired} !== {17'h0, 32'd0}) begin n_fail++; $display("FAIL rst_mid_async got=%h/%0d exp=0/0", ctl, retired); end
    @(negedge clk); resetn = 1'b1; #1;
    n_checks++; if (ctl !== 17'h0) begin n_fail++; $display("FAIL rst_mid_idle got=%h exp=0", ctl); end
    @(negedge clk); #1;
    n_checks++; if ({imem_req, dmem_req, retired} !== {2'b10, 32'd0}) begin n_fail++; $display("FAIL rst_mid_fetch got=%b/%0d exp=10/0", {imem_req, dmem_req}, retired); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_classes();
    test_load();
    test_branch();
    test_illegal();
    test_store_timeout();
    test_wrap();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
